// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the time-multiplexed FIR MAC scheduler.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Full product width plus enough guard bits to sum N products without overflow.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting after the last winner.
// Zero latency; the pointer only advances when the grant is actually taken.
module fir_rr_arbiter #(
  parameter int NCH = 4,
  parameter int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] req,
  input  logic           accept,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  grant_idx,
  output logic           any
);

  logic [IW-1:0] last;
  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = IW'((int'(last) + 1 + i) % NCH);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        any         = 1'b1;
      end
    end
  end

  // Reset to the last channel so channel 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IW'(NCH - 1);
    end else if (accept) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// One shared MAC serving NCH channels round-robin; N MAC cycles per sample, result at +N.
// Requests and coefficient writes are only accepted in IDLE; results hold until out_ready.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int NCH   = 4,
  parameter int AW    = (N > 1) ? $clog2(N) : 1,
  parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1,
  parameter int ACC_W = acc_width(WIDTH, N)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NCH-1:0]             req_valid,
  input  logic [NCH-1:0][WIDTH-1:0]  req_data,
  output logic [NCH-1:0]             req_ready,
  input  logic                       coef_we,
  input  logic [AW-1:0]              coef_addr,
  input  logic signed [WIDTH-1:0]    coef_wdata,
  output logic                       coef_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CW-1:0]              out_ch,
  output logic signed [ACC_W-1:0]    out_data
);

  state_t                   state;
  logic [AW-1:0]            tap;
  logic [CW-1:0]            cur_ch;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [WIDTH-1:0]  h   [N];
  logic signed [WIDTH-1:0]  dly [NCH][N];

  logic [NCH-1:0] grant;
  logic [CW-1:0]  grant_idx;
  logic           grant_any;
  logic           arb_en;
  logic           accept;
  logic           addr_ok;

  // Coefficient writes take priority over sample grants in IDLE.
  assign arb_en     = rst_n && (state == IDLE) && !coef_we;
  assign req_ready  = arb_en ? grant : '0;
  assign accept     = arb_en && grant_any;
  assign coef_ready = rst_n && (state == IDLE);

  assign prod = dly[cur_ch][tap] * h[tap];
  assign sum  = acc + ACC_W'(prod);

  generate
    if ((1 << AW) == N) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign addr_ok = int'(coef_addr) < N;
    end
  endgenerate

  fir_rr_arbiter #(
    .NCH (NCH)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tap       <= '0;
      cur_ch    <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      for (int k = 0; k < N; k++) begin
        h[k] <= '0;
      end
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < N; k++) begin
          dly[c][k] <= '0;
        end
      end
    end else begin
      case (state)
        IDLE: begin
          if (coef_we) begin
            if (addr_ok) begin
              h[coef_addr] <= coef_wdata;
            end
          end else if (grant_any) begin
            dly[grant_idx][0] <= req_data[grant_idx];
            for (int k = 1; k < N; k++) begin
              dly[grant_idx][k] <= dly[grant_idx][k-1];
            end
            acc    <= '0;
            tap    <= '0;
            cur_ch <= grant_idx;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          tap <= tap + 1'b1;
          if (tap == AW'(N - 1)) begin
            out_data  <= sum;
            out_ch    <= cur_ch;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fir_mac_scheduler.md
Name: fir_mac_scheduler

Overview:
Time-multiplexed FIR engine controller. It shares one signed multiply-accumulate unit among NCH sample requesters using round-robin arbitration. Per granted sample it keeps a private N-tap delay line per channel and sequences N MAC cycles over a shared, runtime-writable coefficient bank. It sits in front of the filter datapath and replaces NCH parallel fir_filter instances where throughput allows.

Parameters:
WIDTH, 16, sample and coefficient width (signed)
N, 8, taps per channel
NCH, 4, number of requesting channels

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NCH  per-channel sample valid
req_data  in  NCH x WIDTH  per-channel signed sample (packed [NCH-1:0][WIDTH-1:0])
req_ready  out  NCH  per-channel accept; one-hot or zero
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(N)  tap index
coef_wdata  in  WIDTH  signed coefficient
coef_ready  out  1  coefficient write accepted this cycle when coef_we is high
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_ch  out  $clog2(NCH)  channel of result
out_data  out  ACC_W=2*WIDTH+$clog2(N)+1  signed filter result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, out_ch=0, out_data=0; req_ready=0; coef_ready=0 during reset. All delay lines, coefficients and the accumulator are 0. The round-robin pointer is set so that channel 0 has highest priority.
- FSM has three states: IDLE, MAC, DONE.
- IDLE, coefficient writes:
  - coef_ready=1 in IDLE; 0 in MAC and DONE.
  - coef_we=1 in IDLE writes h[coef_addr] at the edge. No grant is issued that cycle (coefficients win).
- IDLE, arbitration (when coef_we=0):
  - Round-robin search starts at last_grant+1 mod NCH over req_valid.
  - The winner g gets req_ready[g]=1 combinationally, same cycle. Handshake = req_valid[g] & req_ready[g].
  - At the edge: delay[g][0]<=req_data[g], delay[g][k]<=delay[g][k-1]; acc<=0; tap<=0; cur_ch<=g; last_grant<=g; go to MAC.
  - No valid request: stay in IDLE.
- MAC: each cycle acc<=acc+sext(delay[cur_ch][tap]*h[tap]); tap++. On tap==N-1, go to DONE, loading out_data with the final sum, out_ch<=cur_ch and out_valid<=1.
- DONE:
  - out_valid, out_data and out_ch are held stable until out_ready=1. On that edge, out_valid<=0 and the FSM goes to IDLE.
  - req_ready=0 in MAC and DONE.
- Latency: handshake at edge T leaves out_valid high from edge T+N onward. Minimum per-sample period is N+2 cycles.
- Arithmetic:
  - Product is full 2*WIDTH signed.
  - Accumulator is ACC_W signed; products are sign-extended, so no overflow is possible.
  - Result equals sum over j of x_c[i-j]*h[j], where samples before reset count as 0.
- Boundary conditions:
  - Requester drops req_valid while not granted: legal; it is simply not served.
  - A channel's delay line is untouched while other channels are served.
  - Coefficient writes in MAC/DONE are ignored (coef_ready=0); the writer must hold coef_we.
  - coef_addr>=N (when N is not a power of 2): the write is dropped, with coef_ready still 1.
  - Async reset mid-MAC or mid-DONE: the result is lost, out_valid=0 immediately, history and coefficients are cleared.

Decomposition:
- fir_pkg: state enum (IDLE/MAC/DONE) and acc_width(WIDTH,N) function.
- Sub-module fir_rr_arbiter (NCH requests, pointer, one-hot grant plus index). It is combinational with a registered pointer update on the accept pulse.

Test Plan:
- Coef h=1..8 written via port in IDLE; channel 0 sends x=1,2,3,4,5 with out_ready=1 -> out_data 1,4,10,20,35 with out_ch=0; each out_valid rises 8 cycles after its handshake.
- Channels 0 and 1 hold req_valid continuously (ch0 x=1,2; ch1 x=100,200), h=1..8 -> grants alternate 0,1,0,1; results 1 (ch0), 100 (ch1), 4 (ch0), 400 (ch1).
- out_ready low for 5 cycles in DONE -> out_valid, out_data and out_ch stable; req_ready=0 and coef_ready=0 throughout; the next grant comes the cycle after the accept.
- coef_we asserted during MAC -> coef_ready=0 and h unchanged. Held until IDLE -> written. Simultaneous req_valid in that IDLE cycle -> no grant that cycle, grant on the following cycle.
- All h=-32768 and eight samples of x=-32768 on channel 2 -> final out_data=+8589934592 (2^33), no wrap.
- rst_n pulsed low mid-MAC -> out_valid=0 at once. After release, h reloaded to 1..8 and x=5 on channel 0 -> result 5 (history cleared).
